// File: rtl/dbg_bus_reg_slave.sv
// Debug bus responder backing a bank of 32-bit debug registers.
// Bus requests get an optional wait delay and a grant, then a registered response one cycle later.
module dbg_bus_reg_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h1A11_0000),
  parameter int                    WAIT_CYCLES = 0,
  localparam int                   IDX_W       = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] add_i,
  input  logic                  wen_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            be_i,
  output logic                  gnt_o,
  output logic                  r_valid_o,
  output logic [31:0]           r_rdata_o,
  output logic                  r_opc_o,
  input  logic [IDX_W-1:0]      reg_rd_idx_i,
  output logic [31:0]           reg_rd_data_o,
  input  logic                  hw_we_i,
  input  logic [IDX_W-1:0]      hw_idx_i,
  input  logic [31:0]           hw_wdata_i
);

  localparam logic [ADDR_WIDTH-1:0] SPAN      = ADDR_WIDTH'(4 * NUM_REGS);
  localparam logic [3:0]            WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            r_valid_q, r_valid_d;
  logic [31:0]     r_rdata_q, r_rdata_d;
  logic            r_opc_q, r_opc_d;
  logic [31:0]     regs_q [NUM_REGS];
  logic [31:0]     regs_d [NUM_REGS];

  logic [ADDR_WIDTH-1:0] off_s;
  logic                  hit_s;
  logic [IDX_W-1:0]      bus_idx_s;
  logic                  gnt_s;
  logic                  bus_wr_s;

  // Address decode: word-aligned offsets inside the register window hit.
  always_comb begin
    off_s     = add_i - BASE_ADDR;
    hit_s     = (add_i >= BASE_ADDR) && (off_s < SPAN) && (add_i[1:0] == 2'b00);
    bus_idx_s = off_s[IDX_W+1:2];
  end

  // Grant FSM; an abandoned wait returns to idle without a grant.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          if (WAIT_CYCLES == 0) begin
            gnt_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end else begin
          cnt_d = 4'd0;
        end
      end
      ST_WAIT: begin
        if (!req_i) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          gnt_s   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (rst) begin
      gnt_s = 1'b0;
    end else begin
      gnt_s = gnt_s;
    end
  end

  assign bus_wr_s = gnt_s && !wen_i && hit_s;

  // Register bank update: a bus write to the same word drops the local update entirely.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (hw_we_i && !(bus_wr_s && (bus_idx_s == hw_idx_i))) begin
      regs_d[hw_idx_i] = hw_wdata_i;
    end else begin
      regs_d[hw_idx_i] = regs_d[hw_idx_i];
    end
    if (bus_wr_s) begin
      for (int l = 0; l < 4; l++) begin
        if (be_i[l]) begin
          regs_d[bus_idx_s][8*l +: 8] = wdata_i[8*l +: 8];
        end else begin
          regs_d[bus_idx_s][8*l +: 8] = regs_q[bus_idx_s][8*l +: 8];
        end
      end
    end else begin
      regs_d[bus_idx_s] = regs_d[bus_idx_s];
    end
  end

  // Response: read data is the pre-edge register value; misses return error with zero data.
  always_comb begin
    r_valid_d = gnt_s;
    r_rdata_d = r_rdata_q;
    r_opc_d   = r_opc_q;
    if (gnt_s) begin
      if (!hit_s) begin
        r_opc_d   = 1'b1;
        r_rdata_d = 32'h0;
      end else if (wen_i) begin
        r_opc_d   = 1'b0;
        r_rdata_d = regs_q[bus_idx_s];
      end else begin
        r_opc_d   = 1'b0;
        r_rdata_d = 32'h0;
      end
    end else begin
      r_opc_d = r_opc_q;
    end
  end

  // State, response and register bank flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      r_valid_q <= 1'b0;
      r_rdata_q <= 32'h0;
      r_opc_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 32'h0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_valid_q <= r_valid_d;
      r_rdata_q <= r_rdata_d;
      r_opc_q   <= r_opc_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign gnt_o         = gnt_s;
  assign r_valid_o     = r_valid_q;
  assign r_rdata_o     = r_rdata_q;
  assign r_opc_o       = r_opc_q;
  assign reg_rd_data_o = regs_q[reg_rd_idx_i];

endmodule
